uart_bit_serializer: RTL and testbench

Transmit-side counterpart of the UART bit detector. Accepts parallel data words over a valid/ready handshake and drives a UART frame on `bitstream_out`: start bit, data LSB first, optional parity, one or two stop bits. Each bit is held for 16 or 8 `clk` cycles according to the same `oversample_x16` setting used by the receive path, so `clk` is the shared oversample clock. Output drives the pad directly; idle line is high.

---
 rtl/uart_bit_serializer.sv | 139 +++++++++++++
 tb/tb_uart_bit_serializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bit_serializer.sv
// UART transmit serializer: accepts a parallel word over valid/ready and
// drives start bit, data (LSB first), optional parity and one or two stop
// bits. Each bit lasts 16 or 8 clk cycles, selected per frame.
module uart_bit_serializer #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic                 bitstream_out,
  output logic                 tx_busy,
  input  logic                 oversample_x16,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_reg;
  logic [3:0]           sample_cnt_reg;
  logic [IDX_W-1:0]     bit_idx_reg;
  logic                 stop_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit_reg;
  logic                 x16_reg;
  logic                 parity_en_reg;
  logic                 two_stop_reg;
  logic                 bitstream_reg;
  logic                 busy_reg;

  logic last_sample;
  logic final_stop;
  logic accept;

  // Bit boundary: the sample counter reaches N-1 for the latched rate.
  assign last_sample = x16_reg ? (sample_cnt_reg == 4'd15) : (sample_cnt_reg == 4'd7);

  // Last cycle of the last stop bit: a new word may be taken here so the
  // next start bit follows with no idle gap.
  assign final_stop = (state_reg == STOP) && last_sample && (stop_cnt_reg == two_stop_reg);

  assign data_in_ready = !rst && ((state_reg == IDLE) || final_stop);
  assign accept        = data_in_valid && data_in_ready;

  assign bitstream_out = bitstream_reg;
  assign tx_busy       = busy_reg;

  // Frame sequencer: line level and busy flag are registered so the pad
  // only changes on bit boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      sample_cnt_reg <= 4'd0;
      bit_idx_reg    <= '0;
      stop_cnt_reg   <= 1'b0;
      shift_reg      <= '0;
      parity_bit_reg <= 1'b0;
      x16_reg        <= 1'b0;
      parity_en_reg  <= 1'b0;
      two_stop_reg   <= 1'b0;
      bitstream_reg  <= 1'b1;
      busy_reg       <= 1'b0;
    end else if (accept) begin
      // Latch word and settings; the start bit goes out on this same edge.
      state_reg      <= START;
      sample_cnt_reg <= 4'd0;
      bit_idx_reg    <= '0;
      stop_cnt_reg   <= 1'b0;
      shift_reg      <= data_in;
      parity_bit_reg <= (^data_in) ^ parity_odd;
      x16_reg        <= oversample_x16;
      parity_en_reg  <= parity_en;
      two_stop_reg   <= two_stop;
      bitstream_reg  <= 1'b0;
      busy_reg       <= 1'b1;
    end else if (state_reg == IDLE) begin
      bitstream_reg <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      sample_cnt_reg <= last_sample ? 4'd0 : sample_cnt_reg + 4'd1;
      if (last_sample) begin
        case (state_reg)
          START: begin
            state_reg     <= DATA;
            bitstream_reg <= shift_reg[0];
          end
          DATA: begin
            if (bit_idx_reg == LAST_IDX) begin
              if (parity_en_reg) begin
                state_reg     <= PARITY;
                bitstream_reg <= parity_bit_reg;
              end else begin
                state_reg     <= STOP;
                bitstream_reg <= 1'b1;
              end
            end else begin
              // Shift right so the next data bit is always at position 0.
              bit_idx_reg   <= bit_idx_reg + IDX_W'(1);
              shift_reg     <= shift_reg >> 1;
              bitstream_reg <= shift_reg[1];
            end
          end
          PARITY: begin
            state_reg     <= STOP;
            bitstream_reg <= 1'b1;
          end
          STOP: begin
            if (stop_cnt_reg == two_stop_reg) begin
              state_reg     <= IDLE;
              bitstream_reg <= 1'b1;
              busy_reg      <= 1'b0;
            end else begin
              stop_cnt_reg  <= 1'b1;
              bitstream_reg <= 1'b1;
            end
          end
          default: begin
            state_reg     <= IDLE;
            bitstream_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_bit_serializer.sv
// Bench for uart_bit_serializer: an 8-bit and a 5-bit instance are compared
// cycle by cycle against a frame-level reference model.
module tb_uart_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data0 = 8'h00;
  logic [4:0] data1 = 5'h00;
  logic [1:0] valid = 2'b00;
  logic       os = 1'b1;
  logic       pen = 1'b0;
  logic       podd = 1'b0;
  logic       two = 1'b0;
  logic [1:0] ready;
  logic [1:0] line;
  logic [1:0] busy;

  always #5 clk = ~clk;

  uart_bit_serializer #(.DATA_BITS(8)) dut0 (
    .clk(clk), .rst(rst), .data_in(data0), .data_in_valid(valid[0]),
    .data_in_ready(ready[0]), .bitstream_out(line[0]), .tx_busy(busy[0]),
    .oversample_x16(os), .parity_en(pen), .parity_odd(podd), .two_stop(two)
  );

  uart_bit_serializer #(.DATA_BITS(5)) dut1 (
    .clk(clk), .rst(rst), .data_in(data1), .data_in_valid(valid[1]),
    .data_in_ready(ready[1]), .bitstream_out(line[1]), .tx_busy(busy[1]),
    .oversample_x16(os), .parity_en(pen), .parity_odd(podd), .two_stop(two)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a frame is a list of bit levels, each lasting nn cycles.
  bit          act[2];
  int          pos[2];
  int          flen[2];
  int          nn[2] = '{16, 16};
  logic [15:0] fb[2];
  bit          acc[2];
  int          busy_cyc[2];
  int          dut_acc[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready(input int u);
    return !rst && (!act[u] || pos[u] == flen[u] - 1);
  endfunction

  // Model update on each rising edge.
  initial forever begin
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      automatic bit         rdy = m_ready(u);
      automatic logic [8:0] w   = (u == 0) ? {1'b0, data0} : {4'b0, data1};
      automatic int         nb  = (u == 0) ? 8 : 5;
      automatic bit         par = 1'b0;
      if (valid[u] && ready[u]) dut_acc[u]++;
      acc[u] = 1'b0;
      if (rst) begin
        act[u] = 1'b0;
      end else if (valid[u] && rdy) begin
        nn[u] = os ? 16 : 8;
        fb[u] = '1;
        fb[u][0] = 1'b0;
        for (int i = 0; i < nb; i++) begin
          fb[u][1+i] = w[i];
          par ^= w[i];
        end
        if (pen) fb[u][1+nb] = par ^ podd;
        flen[u] = nn[u] * (2 + nb + (pen ? 1 : 0) + (two ? 1 : 0));
        pos[u] = 0;
        act[u] = 1'b1;
        acc[u] = 1'b1;
      end else if (act[u]) begin
        pos[u]++;
        if (pos[u] == flen[u]) act[u] = 1'b0;
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  initial forever begin
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check(u == 0 ? "u0.line" : "u1.line", line[u], act[u] ? fb[u][pos[u] / nn[u]] : 1'b1);
      check(u == 0 ? "u0.busy" : "u1.busy", busy[u], act[u]);
      check(u == 0 ? "u0.ready" : "u1.ready", ready[u], m_ready(u));
      if (busy[u]) busy_cyc[u]++;
    end
  end

  task automatic wait_acc(input int u);
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!acc[u] && k < 5000);
  endtask

  task automatic wait_idle(input int u);
    int k = 0;
    while (act[u] && k < 5000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("busy_after_frame", busy[u], 1'b0);
  endtask

  task automatic send(input int u, input logic [8:0] w);
    @(negedge clk);
    #1;
    if (u == 0) data0 = w[7:0];
    else data1 = w[4:0];
    valid[u] = 1'b1;
    wait_acc(u);
    @(negedge clk);
    #1;
    valid[u] = 1'b0;
  endtask

  task automatic frame_test(input string tag, input int u, input logic [8:0] w, input int exp_len);
    int b = busy_cyc[u];
    send(u, w);
    wait_idle(u);
    check(tag, busy_cyc[u] - b, exp_len);
  endtask

  initial begin
    int b;
    int a;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // 8N1 x16, 0xA5 from idle
    frame_test("len_8n1_a5", 0, 9'h0A5, 160);

    // back-to-back 0x00 then 0xFF with valid held high
    b = busy_cyc[0];
    a = dut_acc[0];
    @(negedge clk);
    #1 data0 = 8'h00;
    valid[0] = 1'b1;
    wait_acc(0);
    @(negedge clk);
    #1 data0 = 8'hFF;
    wait_acc(0);
    @(negedge clk);
    #1 valid[0] = 1'b0;
    wait_idle(0);
    check("b2b_len", busy_cyc[0] - b, 320);
    check("b2b_accepts", dut_acc[0] - a, 2);

    // 8O1 and 8E1
    pen = 1'b1;
    podd = 1'b1;
    frame_test("len_8o1_00", 0, 9'h000, 176);
    frame_test("len_8o1_01", 0, 9'h001, 176);
    podd = 1'b0;
    frame_test("len_8e1_00", 0, 9'h000, 176);
    frame_test("len_8e1_01", 0, 9'h001, 176);

    // 8N2 x8, rate toggled mid-frame
    pen = 1'b0;
    two = 1'b1;
    os = 1'b0;
    b = busy_cyc[0];
    send(0, 9'h0FF);
    repeat (20) @(negedge clk);
    #1 os = 1'b1;
    wait_idle(0);
    check("len_8n2_x8", busy_cyc[0] - b, 88);

    // reset during data bit 3, then a clean frame
    two = 1'b0;
    send(0, 9'h05A);
    repeat (68) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    frame_test("len_after_reset", 0, 9'h0C3, 160);

    // 5N1 x16, 5'h15
    frame_test("len_5n1_15", 1, 9'h015, 112);

    // randomized frames, settings and occasional resets
    for (int it = 0; it < 40; it++) begin
      automatic int u = $urandom_range(0, 1);
      @(negedge clk);
      #1;
      os = 1'($urandom);
      pen = 1'($urandom);
      podd = 1'($urandom);
      two = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(u, 9'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 100)) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 40)) @(negedge clk);
          #1 os = ~os;
          pen = ~pen;
          two = ~two;
        end
        wait_idle(u);
      end
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
